// File: rtl/vga_text_console_writer_pkg.sv
// Shared screen geometry, control codes and FSM encoding for the text console writer
// and the VGA text slave it feeds.
package vga_text_pkg;

    localparam int COLS          = 80;
    localparam int ROWS          = 30;
    localparam int WORDS_PER_ROW = COLS / 4;
    localparam int SCREEN_WORDS  = ROWS * WORDS_PER_ROW;

    localparam logic [9:0] CTRL_ADDR = 10'd600;

    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;

    typedef enum logic [2:0] {
        INIT_CLR,
        INIT_CTL,
        IDLE,
        WR_CHAR,
        CLR_ROW,
        CLR_ALL
    } state_t;

    function automatic logic [31:0] rep4(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/vga_text_console_writer_if.sv
// Character stream in, Avalon-MM VRAM writes out; master is the console writer side.
interface vga_text_console_writer_if;
    logic        CHAR_VALID;
    logic [7:0]  CHAR_DATA;
    logic        CHAR_READY;
    logic [9:0]  AVM_ADDR;
    logic        AVM_WRITE;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA;
    logic        AVM_WAITREQ;

    modport master (
        input  CHAR_VALID, CHAR_DATA, AVM_WAITREQ,
        output CHAR_READY, AVM_ADDR, AVM_WRITE, AVM_BYTE_EN, AVM_WRITEDATA
    );

    modport slave (
        output CHAR_VALID, CHAR_DATA, AVM_WAITREQ,
        input  CHAR_READY, AVM_ADDR, AVM_WRITE, AVM_BYTE_EN, AVM_WRITEDATA
    );
endinterface

// File: rtl/vga_text_console_writer_addr_gen.sv
// Maps a (row, col) cell to its VRAM word address and one-hot byte lane.
module vga_text_addr_gen
    import vga_text_pkg::*;
(
    input  logic [4:0] row_i,
    input  logic [6:0] col_i,
    output logic [9:0] addr_o,
    output logic [3:0] be_o
);
    assign addr_o = 10'(row_i) * 10'(WORDS_PER_ROW) + 10'(col_i[6:2]);
    assign be_o   = 4'b0001 << col_i[1:0];
endmodule

// File: rtl/vga_text_console_writer.sv
// Avalon-MM master converting a character stream into text-mode VRAM writes,
// with cursor tracking, control codes, screen/row clears and post-reset init.
module vga_text_console_writer
    import vga_text_pkg::*;
#(
    parameter logic [31:0] INIT_CTRL = 32'h01FE_0000,
    parameter logic [7:0]  BLANK     = 8'h00
) (
    input  logic                              CLK,
    input  logic                              RESET_N,
    vga_text_console_writer_if.master         bus,
    output logic [6:0]                        CURSOR_COL,
    output logic [4:0]                        CURSOR_ROW,
    output logic                              BUSY
);
    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [7:0]  chr_q, chr_d;
    logic        bs_q, bs_d;
    logic        wr_q, wr_d;
    logic [9:0]  addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] data_q, data_d;

    logic [9:0]  gen_addr, sweep_len;
    logic [3:0]  gen_be;
    logic        done, issue_ok;

    // Column forced to 0 outside WR_CHAR so the same generator yields the row base for CLR_ROW.
    vga_text_addr_gen u_addr_gen (
        .row_i  (row_q),
        .col_i  ((state_q == WR_CHAR) ? col_q : 7'd0),
        .addr_o (gen_addr),
        .be_o   (gen_be)
    );

    assign done      = wr_q && !bus.AVM_WAITREQ;
    assign issue_ok  = !wr_q || !bus.AVM_WAITREQ;
    assign sweep_len = (state_q == CLR_ROW) ? 10'(WORDS_PER_ROW) : 10'(SCREEN_WORDS);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        chr_d   = chr_q;
        bs_d    = bs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        data_d  = data_q;
        case (state_q)
            INIT_CLR, CLR_ALL, CLR_ROW: begin
                // cnt_q counts words already issued; the sweep ends when the last one completes.
                if (issue_ok) begin
                    if (wr_q && cnt_q == sweep_len) begin
                        cnt_d = '0;
                        if (state_q == INIT_CLR) begin
                            addr_d  = CTRL_ADDR;
                            be_d    = 4'hF;
                            data_d  = INIT_CTRL;
                            state_d = INIT_CTL;
                        end else begin
                            wr_d    = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        wr_d   = 1'b1;
                        addr_d = gen_addr + cnt_q;
                        be_d   = 4'hF;
                        data_d = rep4(BLANK);
                        cnt_d  = cnt_q + 10'd1;
                    end
                end
            end
            INIT_CTL: begin
                if (done) begin
                    wr_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.CHAR_VALID) begin
                    case (bus.CHAR_DATA)
                        CC_CR: col_d = '0;
                        CC_LF: begin
                            if (row_q == 5'(ROWS - 1)) begin
                                row_d   = '0;
                                cnt_d   = '0;
                                state_d = CLR_ROW;
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end
                        CC_BS: begin
                            if (col_q != '0) begin
                                col_d   = col_q - 7'd1;
                                chr_d   = BLANK;
                                bs_d    = 1'b1;
                                state_d = WR_CHAR;
                            end
                        end
                        CC_FF: begin
                            col_d   = '0;
                            row_d   = '0;
                            cnt_d   = '0;
                            state_d = CLR_ALL;
                        end
                        default: begin
                            chr_d   = bus.CHAR_DATA;
                            bs_d    = 1'b0;
                            state_d = WR_CHAR;
                        end
                    endcase
                end
            end
            WR_CHAR: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = gen_addr;
                    be_d   = gen_be;
                    data_d = rep4(chr_q);
                end else if (done) begin
                    wr_d    = 1'b0;
                    state_d = IDLE;
                    if (!bs_q) begin
                        if (col_q == 7'(COLS - 1)) begin
                            col_d = '0;
                            if (row_q == 5'(ROWS - 1)) begin
                                row_d   = '0;
                                cnt_d   = '0;
                                state_d = CLR_ROW;
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end
                end
            end
            default: state_d = INIT_CLR;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= INIT_CLR;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            chr_q   <= '0;
            bs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            chr_q   <= chr_d;
            bs_q    <= bs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            data_q  <= data_d;
        end
    end

    assign bus.CHAR_READY    = (state_q == IDLE);
    assign bus.AVM_WRITE     = wr_q;
    assign bus.AVM_ADDR      = addr_q;
    assign bus.AVM_BYTE_EN   = be_q;
    assign bus.AVM_WRITEDATA = data_q;
    assign CURSOR_COL        = col_q;
    assign CURSOR_ROW        = row_q;
    assign BUSY              = (state_q != IDLE);
endmodule

// File: tb/tb_vga_text_console_writer.sv
// Scoreboard bench for the text console writer: a cursor model predicts every VRAM write.
module tb_vga_text_console_writer;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic [6:0] CURSOR_COL;
    logic [4:0] CURSOR_ROW;
    logic BUSY;

    vga_text_console_writer_if bus();

    vga_text_console_writer dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .bus        (bus),
        .CURSOR_COL (CURSOR_COL),
        .CURSOR_ROW (CURSOR_ROW),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [9:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  wr_seen = 0;
    int  mcol = 0;
    int  mrow = 0;

    // Write completes at the next posedge when WRITE && !WAITREQ holds at the negedge before it.
    always @(negedge CLK) begin
        if (RESET_N && bus.AVM_WRITE && !bus.AVM_WAITREQ) begin
            wr_t act;
            wr_t e;
            act = '{a: bus.AVM_ADDR, be: bus.AVM_BYTE_EN, d: bus.AVM_WRITEDATA};
            wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d be=%b data=%h, required no write", act.a, act.be, act.d);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL avm_write: got addr=%0d be=%b data=%h, required addr=%0d be=%b data=%h",
                             act.a, act.be, act.d, e.a, e.be, e.d);
                end
            end
        end
    end

    function automatic void push_wr(input int a, input logic [3:0] be, input logic [31:0] d);
        wr_t w;
        w.a = 10'(a);
        w.be = be;
        w.d = d;
        exp_q.push_back(w);
    endfunction

    function automatic void push_cell(input int r, input int c, input logic [7:0] b);
        push_wr(r * 20 + c / 4, 4'(1 << (c % 4)), {4{b}});
    endfunction

    function automatic void model_adv_row();
        if (mrow == 29) begin
            mrow = 0;
            for (int i = 0; i < 20; i++) push_wr(i, 4'hF, 32'h0);
        end else begin
            mrow++;
        end
    endfunction

    function automatic void model_char(input logic [7:0] b);
        case (b)
            8'h0D: mcol = 0;
            8'h0A: model_adv_row();
            8'h08: if (mcol > 0) begin
                mcol--;
                push_cell(mrow, mcol, 8'h00);
            end
            8'h0C: begin
                mcol = 0;
                mrow = 0;
                for (int i = 0; i < 600; i++) push_wr(i, 4'hF, 32'h0);
            end
            default: begin
                push_cell(mrow, mcol, b);
                if (mcol == 79) begin
                    mcol = 0;
                    model_adv_row();
                end else begin
                    mcol++;
                end
            end
        endcase
    endfunction

    function automatic void model_init();
        exp_q.delete();
        mcol = 0;
        mrow = 0;
        for (int i = 0; i < 600; i++) push_wr(i, 4'hF, 32'h0);
        push_wr(600, 4'hF, 32'h01FE_0000);
    endfunction

    task automatic send_char(input logic [7:0] b);
        int n = 0;
        while (!bus.CHAR_READY && n < 3000) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 3000) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: got READY=0 after %0d cycles, required READY=1", n);
        end
        model_char(b);
        bus.CHAR_VALID = 1'b1;
        bus.CHAR_DATA  = b;
        @(posedge CLK); #1;
        bus.CHAR_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (BUSY && n < 5000) begin
            @(posedge CLK); #1;
            n++;
        end
        checks++;
        if (BUSY) begin
            errors++;
            $display("FAIL %s_idle_timeout: got BUSY=1, required BUSY=0", tag);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_writes: got %0d outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if ({CURSOR_ROW, CURSOR_COL} !== {5'(mrow), 7'(mcol)}) begin
            errors++;
            $display("FAIL %s_cursor: got (%0d,%0d), required (%0d,%0d)", tag, CURSOR_COL, CURSOR_ROW, mcol, mrow);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({bus.AVM_WRITE, bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA} !== 47'h0) begin
            errors++;
            $display("FAIL %s_avm: got write=%b addr=%0d be=%b data=%h, required all 0", tag,
                     bus.AVM_WRITE, bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA);
        end
        checks++;
        if ({bus.CHAR_READY, BUSY, CURSOR_COL, CURSOR_ROW} !== {1'b0, 1'b1, 7'd0, 5'd0}) begin
            errors++;
            $display("FAIL %s_ctrl: got ready=%b busy=%b cursor=(%0d,%0d), required ready=0 busy=1 cursor=(0,0)",
                     tag, bus.CHAR_READY, BUSY, CURSOR_COL, CURSOR_ROW);
        end
    endtask

    task automatic test_reset();
        int cyc = 0;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        model_init();
        RESET_N = 1'b1;
        while (!bus.CHAR_READY && cyc < 2000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        checks++;
        if (cyc < 601 || cyc > 603) begin
            errors++;
            $display("FAIL init_ready_latency: got %0d cycles, required 601..603", cyc);
        end
        wait_idle("init");
    endtask

    task automatic test_printable();
        send_char(8'h41);
        wait_idle("char_A");
        send_char(8'h8D);
        wait_idle("inverse_8D");
        send_char(8'h0D);
        checks++;
        if (CURSOR_COL !== 7'd0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL cr_at_accept: got col=%0d busy=%b, required col=0 busy=0", CURSOR_COL, BUSY);
        end
        wait_idle("cr");
    endtask

    task automatic test_waitreq();
        int seen0;
        int n = 0;
        logic [46:0] held;
        bus.AVM_WAITREQ = 1'b1;
        seen0 = wr_seen;
        send_char(8'h5A);
        while (!bus.AVM_WRITE && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        held = {bus.AVM_WRITE, bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA};
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK); #1;
            checks++;
            if ({bus.AVM_WRITE, bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA} !== held ||
                held[46] !== 1'b1 || CURSOR_COL !== 7'd0) begin
                errors++;
                $display("FAIL waitreq_hold: got avm=%h col=%0d, required avm=%h with write=1 col=0",
                         {bus.AVM_WRITE, bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA}, CURSOR_COL, held);
            end
        end
        bus.AVM_WAITREQ = 1'b0;
        wait_idle("waitreq");
        checks++;
        if (wr_seen - seen0 != 1) begin
            errors++;
            $display("FAIL waitreq_count: got %0d writes, required 1", wr_seen - seen0);
        end
    endtask

    task automatic test_wrap();
        int lowc = 0;
        send_char(8'h0C);
        wait_idle("ff");
        for (int i = 0; i < 29; i++) send_char(8'h0A);
        for (int i = 0; i < 79; i++) send_char(8'h78);
        wait_idle("pos_79_29");
        send_char(8'hC1);
        while (!bus.CHAR_READY && lowc < 100) begin
            @(posedge CLK); #1;
            lowc++;
        end
        checks++;
        if (lowc < 22) begin
            errors++;
            $display("FAIL wrap_ready_low: got READY back after %0d cycles, required at least 22", lowc);
        end
        wait_idle("wrap");
    endtask

    task automatic test_backspace();
        int seen0;
        for (int i = 0; i < 3; i++) send_char(8'h0A);
        for (int i = 0; i < 5; i++) send_char(8'h62);
        wait_idle("pos_5_3");
        send_char(8'h08);
        wait_idle("bs");
        send_char(8'h0D);
        seen0 = wr_seen;
        send_char(8'h08);
        repeat (4) @(posedge CLK);
        #1;
        checks++;
        if (wr_seen != seen0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL bs_col0: got %0d writes busy=%b, required 0 writes busy=0", wr_seen - seen0, BUSY);
        end
        wait_idle("bs_col0");
    endtask

    task automatic test_reset_midclear();
        send_char(8'h0C);
        repeat (50) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midclear_reset");
        model_init();
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        wait_idle("reinit");
    endtask

    initial begin
        bus.CHAR_VALID  = 1'b0;
        bus.CHAR_DATA   = 8'h00;
        bus.AVM_WAITREQ = 1'b0;
        test_reset();
        test_printable();
        test_waitreq();
        test_wrap();
        test_backspace();
        test_reset_midclear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
